// File: rtl/arbiter_rr.sv
// N-requester bus arbiter with registered one-hot grant, fixed-priority or round-robin
// selection, grant hold, bus lock and a hold-timeout that pre-empts a hogging owner.
module arbiter_rr #(
    parameter int unsigned N        = 4,
    parameter int unsigned RR_MODE  = 1,
    parameter int unsigned MAX_HOLD = 8,
    localparam int unsigned IdW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic           i_clk,
    input  logic           i_nrst,
    input  logic [N-1:0]   i_req,
    input  logic           i_lock,
    output logic [N-1:0]   o_gnt,
    output logic [IdW-1:0] o_gnt_id,
    output logic           o_busy,
    output logic           o_preempt
);

    localparam int unsigned CntW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_HOLD);
    localparam logic [CntW-1:0] CntOne = (MAX_HOLD == 0) ? '0 : CntW'(1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IdW-1:0]  id_q, id_d;
    logic [IdW-1:0]  ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            preempt_q, preempt_d;

    logic [N-1:0]    cand;
    logic            found;
    logic [IdW-1:0]  win;
    logic [IdW-1:0]  ptr_nxt;
    logic [IdW-1:0]  j;
    logic [CntW-1:0] cnt_inc;
    logic            grant_new;

    // Candidates exclude the current owner; when idle gnt_q is zero so the mask is all ones.
    always_comb begin
        cand  = i_req & ~gnt_q;
        found = 1'b0;
        win   = '0;
        j     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (RR_MODE != 0) ? IdW'((32'(ptr_q) + i) % N) : IdW'(i);
            if (!found && cand[j]) begin
                found = 1'b1;
                win   = j;
            end
        end
        ptr_nxt = (32'(win) == N - 1) ? '0 : win + 1'b1;
        cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            id_q      <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        grant_new = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_new = 1'b1;
                end
            end
            StGrant: begin
                if (!i_req[id_q]) begin
                    // Release beats lock and timeout; hand over with no idle cycle.
                    if (found) begin
                        grant_new = 1'b1;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                        id_d    = '0;
                        cnt_d   = '0;
                    end
                end else if (i_lock) begin
                    cnt_d = cnt_inc;
                end else if (MAX_HOLD != 0 && cnt_q == CntMax && found) begin
                    grant_new = 1'b1;
                    preempt_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: ;
        endcase
        if (grant_new) begin
            state_d   = StGrant;
            gnt_d     = '0;
            gnt_d[win] = 1'b1;
            id_d      = win;
            ptr_d     = ptr_nxt;
            cnt_d     = CntOne;
        end
    end

    always_comb begin
        o_gnt     = gnt_q;
        o_gnt_id  = id_q;
        o_busy    = |gnt_q;
        o_preempt = preempt_q;
    end

endmodule

// File: tb/tb_arbiter_rr.sv
// Directed bench for arbiter_rr: a round-robin/timeout instance and a fixed-priority,
// no-timeout instance, each checked against hand-computed grants.
module tb_arbiter_rr;

    logic       clk = 1'b0;
    logic       nrst;
    logic [3:0] req, req_f;
    logic       lock;
    logic [3:0] gnt, gnt_f;
    logic [1:0] id, id_f;
    logic       busy, busy_f, pre, pre_f;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    arbiter_rr #(.N(4), .RR_MODE(1), .MAX_HOLD(8)) u_dut (
        .i_clk     (clk),
        .i_nrst    (nrst),
        .i_req     (req),
        .i_lock    (lock),
        .o_gnt     (gnt),
        .o_gnt_id  (id),
        .o_busy    (busy),
        .o_preempt (pre)
    );

    arbiter_rr #(.N(4), .RR_MODE(0), .MAX_HOLD(0)) u_fix (
        .i_clk     (clk),
        .i_nrst    (nrst),
        .i_req     (req_f),
        .i_lock    (1'b0),
        .o_gnt     (gnt_f),
        .o_gnt_id  (id_f),
        .o_busy    (busy_f),
        .o_preempt (pre_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r = '0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic chk_d(input string tag, input logic [3:0] eg, input logic ep);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".id"}, 32'(id), 32'(idx_of(eg)));
        chk({tag, ".busy"}, 32'(busy), 32'(|eg));
        chk({tag, ".pre"}, 32'(pre), 32'(ep));
    endtask

    task automatic chk_f(input string tag, input logic [3:0] eg);
        chk({tag, ".gnt"}, 32'(gnt_f), 32'(eg));
        chk({tag, ".id"}, 32'(id_f), 32'(idx_of(eg)));
        chk({tag, ".busy"}, 32'(busy_f), 32'(|eg));
        chk({tag, ".pre"}, 32'(pre_f), 32'(0));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst  = 1'b1;
        req   = 4'b1111;
        req_f = 4'b0000;
        lock  = 1'b0;
        #1 nrst = 1'b0;
        #1 chk_d("rst_async", 4'b0000, 1'b0);
        step();
        step();
        chk_d("rst_hold", 4'b0000, 1'b0);
        chk_f("rst_fix", 4'b0000);
        #3 nrst = 1'b1;
        step();
        chk_d("rst_first", 4'b0001, 1'b0);

        // Rotation: owner drops its bit for one cycle at a time.
        req = 4'b1110; step(); chk_d("rr1", 4'b0010, 1'b0);
        req = 4'b1101; step(); chk_d("rr2", 4'b0100, 1'b0);
        req = 4'b1011; step(); chk_d("rr3", 4'b1000, 1'b0);
        req = 4'b0111; step(); chk_d("rr4", 4'b0001, 1'b0);
        req = 4'b0000; step(); chk_d("idle1", 4'b0000, 1'b0);

        // Timeout: owner 2, master 0 joins at grant cycle 3.
        req = 4'b0100; step(); chk_d("to_g1", 4'b0100, 1'b0);
        step(); chk_d("to_g2", 4'b0100, 1'b0);
        step(); chk_d("to_g3", 4'b0100, 1'b0);
        req = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            step(); chk_d("to_hold", 4'b0100, 1'b0);
        end
        step(); chk_d("to_pre", 4'b0001, 1'b1);
        step(); chk_d("to_after", 4'b0001, 1'b0);

        // Lock while idle is ignored; lock on an owner suppresses the timeout.
        req = 4'b0000; step(); chk_d("idle2", 4'b0000, 1'b0);
        lock = 1'b1; step(); chk_d("lock_idle", 4'b0000, 1'b0);
        req = 4'b0100; step(); chk_d("lk_g1", 4'b0100, 1'b0);
        req = 4'b0101;
        for (int i = 0; i < 20; i++) begin
            step(); chk_d("lk_hold", 4'b0100, 1'b0);
        end
        lock = 1'b0; step(); chk_d("lk_pre", 4'b0001, 1'b1);
        step(); chk_d("lk_after", 4'b0001, 1'b0);

        // Release on the same edge the timeout would fire.
        req = 4'b0000; step(); chk_d("idle3", 4'b0000, 1'b0);
        req = 4'b0100; step(); chk_d("col_g1", 4'b0100, 1'b0);
        req = 4'b0101;
        for (int i = 0; i < 7; i++) begin
            step(); chk_d("col_hold", 4'b0100, 1'b0);
        end
        req = 4'b0001; step(); chk_d("col_rel", 4'b0001, 1'b0);

        // Async reset mid-grant, then first grant judged with ptr=0.
        #1 nrst = 1'b0;
        #1 chk_d("rst_mid", 4'b0000, 1'b0);
        req = 4'b0011;
        #2 nrst = 1'b1;
        step(); chk_d("rst_ptr0", 4'b0001, 1'b0);
        step(); chk_d("rst_keep", 4'b0001, 1'b0);
        req = 4'b0010; step(); chk_d("rst_next", 4'b0010, 1'b0);
        req = 4'b0000;

        // Fixed priority, no timeout.
        req_f = 4'b1010; step(); chk_f("fx1", 4'b0010);
        req_f = 4'b1011; step(); chk_f("fx_keep", 4'b0010);
        req_f = 4'b1001; step(); chk_f("fx_rel", 4'b0001);
        req_f = 4'b1011;
        for (int i = 0; i < 12; i++) begin
            step(); chk_f("fx_hold", 4'b0001);
        end
        req_f = 4'b1010; step(); chk_f("fx_low", 4'b0010);
        req_f = 4'b0000; step(); chk_f("fx_idle", 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
